// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg_pkg
// Brief  : Shared constants for the seven-segment scan display stage:
//          hex-to-segment table (active low, [6:0] = g,f,e,d,c,b,a),
//          all-off codes for segments and digit enables, and the
//          digit-position indices used by the scanner.
// Rev    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Digit pointer type: selects one of the four display positions.
    typedef logic [1:0] dig_ptr_t;

    // All segments dark (dp included) and all digit enables released.
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] DIG_OFF = 4'hF;

    // Display positions, [0] is the rightmost digit.
    localparam dig_ptr_t DIG_Q    = 2'd0;
    localparam dig_ptr_t DIG_SEP  = 2'd1;
    localparam dig_ptr_t DIG_ONES = 2'd2;
    localparam dig_ptr_t DIG_TENS = 2'd3;

    // Active-low segment patterns for 0..F.
    localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module : hex7seg
// Brief  : Combinational 4-bit value to active-low seven-segment decoder.
// Ports  : hex   [3:0] in  - value to display
//          seg_n [6:0] out - segments g,f,e,d,c,b,a, active low
// Rev    : 1.0  initial release
// ============================================================================
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG_TABLE[hex];

endmodule : hex7seg
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module : seg_scan
// Brief  : Four-digit common-anode display scanner. Shows the live counter
//          value (digit 0, dp = carry), a blank separator (digit 1) and a
//          two-digit BCD count of carry rollovers (digits 2/3). Digits are
//          advanced by the 1 kHz scan clock, with a blanking gap after each
//          advance to suppress ghosting.
// Ports  : clk_50mhz        in  - system clock
//          rst              in  - asynchronous reset, active low
//          scan_clk         in  - 1 kHz scan clock, asynchronous, data only
//          q_in     [3:0]   in  - counter value, asynchronous
//          rco_in           in  - counter ripple carry, asynchronous
//          seg_n    [7:0]   out - segments, active low, [7]=dp
//          dig_n    [3:0]   out - digit enables, active low, [0]=rightmost
// Rev    : 1.0  initial release
// ============================================================================
module seg_scan
    import seg_pkg::*;
#(
    parameter int BLANK_CYC = 50,   // blanking cycles after each advance (1..1000)
    parameter int LZB       = 1     // 1 = suppress a leading-zero tens digit
)(
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       scan_clk,
    input  logic [3:0] q_in,
    input  logic       rco_in,
    output logic [7:0] seg_n,
    output logic [3:0] dig_n
);

    localparam int             BW           = $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0]  c_blank_load = BW'(BLANK_CYC);

    // Scan FSM: idle until the first scan tick, then alternate blank/show.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // ------------------------------------------------------------------
    // Synchronizers and edge detectors
    // ------------------------------------------------------------------
    logic       r_scan_s1, r_scan_s2, r_scan_d;
    logic       r_rco_s1,  r_rco_s2,  r_rco_d;
    logic [3:0] r_q_s1, r_q_s2, r_q_s3;
    logic [3:0] r_q_held;
    logic       w_scan_tick;
    logic       w_rco_rise;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            r_scan_s1 <= 1'b0;
            r_scan_s2 <= 1'b0;
            r_scan_d  <= 1'b0;
            r_rco_s1  <= 1'b0;
            r_rco_s2  <= 1'b0;
            r_rco_d   <= 1'b0;
            r_q_s1    <= 4'h0;
            r_q_s2    <= 4'h0;
            r_q_s3    <= 4'h0;
            r_q_held  <= 4'h0;
        end else begin
            r_scan_s1 <= scan_clk;
            r_scan_s2 <= r_scan_s1;
            r_scan_d  <= r_scan_s2;
            r_rco_s1  <= rco_in;
            r_rco_s2  <= r_rco_s1;
            r_rco_d   <= r_rco_s2;
            r_q_s1    <= q_in;
            r_q_s2    <= r_q_s1;
            r_q_s3    <= r_q_s2;
            // A bus caught mid-transition shows up as one odd sample; only
            // a value seen on two consecutive cycles is accepted.
            if (r_q_s2 == r_q_s3) begin
                r_q_held <= r_q_s2;
            end
        end
    end

    assign w_scan_tick = r_scan_s2 & ~r_scan_d;
    assign w_rco_rise  = r_rco_s2  & ~r_rco_d;

    // ------------------------------------------------------------------
    // Rollover counter, two BCD digits, wraps 99 -> 00
    // ------------------------------------------------------------------
    logic [3:0] r_ones, r_tens;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else if (w_rco_rise) begin
            if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment decoders
    // ------------------------------------------------------------------
    logic [6:0] w_seg_q, w_seg_ones, w_seg_tens;

    hex7seg u_hex_q    (.hex(r_q_held), .seg_n(w_seg_q));
    hex7seg u_hex_ones (.hex(r_ones),   .seg_n(w_seg_ones));
    hex7seg u_hex_tens (.hex(r_tens),   .seg_n(w_seg_tens));

    // ------------------------------------------------------------------
    // Digit pointer, blank counter and segment register
    // ------------------------------------------------------------------
    dig_ptr_t      r_ptr;
    dig_ptr_t      w_ptr_nxt;
    logic [BW-1:0] r_blank;
    logic [7:0]    r_seg_n;
    logic [7:0]    w_seg_nxt;

    assign w_ptr_nxt = r_ptr + 2'd1;

    // Segment pattern for the digit about to be selected. It is latched
    // together with the pointer so it is settled long before the enable.
    always_comb begin
        w_seg_nxt = SEG_OFF;
        case (w_ptr_nxt)
            DIG_Q:    w_seg_nxt = {~r_rco_s2, w_seg_q};
            DIG_SEP:  w_seg_nxt = SEG_OFF;
            DIG_ONES: w_seg_nxt = {1'b1, w_seg_ones};
            DIG_TENS: w_seg_nxt = ((LZB != 0) && (r_tens == 4'd0)) ?
                                  SEG_OFF : {1'b1, w_seg_tens};
            default:  w_seg_nxt = SEG_OFF;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            r_ptr   <= DIG_Q;
            r_blank <= '0;
            r_seg_n <= SEG_OFF;
        end else if (w_scan_tick) begin
            r_ptr   <= w_ptr_nxt;
            r_blank <= c_blank_load;
            r_seg_n <= w_seg_nxt;
        end else if (r_blank != '0) begin
            r_blank <= r_blank - BW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_scan_tick) w_state_nxt = ST_BLANK;
            end
            ST_BLANK: begin
                // Leave blanking on the cycle the counter reaches zero.
                if (!w_scan_tick && (r_blank == BW'(1))) w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (w_scan_tick) w_state_nxt = ST_BLANK;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dig_n = DIG_OFF;
        if (r_state == ST_SHOW) begin
            dig_n = ~(4'b0001 << r_ptr);
        end
    end

    assign seg_n = r_seg_n;

endmodule : seg_scan
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_seg_scan
// Brief  : Directed self-checking bench for seg_scan (BLANK_CYC=50, LZB=1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_seg_scan;

    logic       clk_50mhz = 1'b0;
    logic       rst       = 1'b0;
    logic       scan_clk  = 1'b0;
    logic       rco_in    = 1'b0;
    logic [3:0] q_in      = 4'h0;
    logic [7:0] seg_n;
    logic [3:0] dig_n;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    seg_scan #(
        .BLANK_CYC (50),
        .LZB       (1)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .scan_clk  (scan_clk),
        .q_in      (q_in),
        .rco_in    (rco_in),
        .seg_n     (seg_n),
        .dig_n     (dig_n)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_digit(input string tag, input logic [3:0] exp_dig, input logic [7:0] exp_seg);
        check_val({tag, "_dig"}, {12'h0, dig_n}, {12'h0, exp_dig});
        check_val({tag, "_seg"}, {8'h0, seg_n},  {8'h0, exp_seg});
    endtask

    // One scan_clk pulse, then wait well past the blanking gap.
    task automatic step();
        @(negedge clk_50mhz);
        scan_clk = 1'b1;
        repeat (4) @(negedge clk_50mhz);
        scan_clk = 1'b0;
        repeat (70) @(negedge clk_50mhz);
    endtask

    task automatic rco_pulses(input int n);
        repeat (n) begin
            @(negedge clk_50mhz);
            rco_in = 1'b1;
            repeat (4) @(negedge clk_50mhz);
            rco_in = 1'b0;
            repeat (4) @(negedge clk_50mhz);
        end
    endtask

    logic viol;
    int   lat;
    logic ok;

    initial begin
        // ---------------- reset held, inputs toggling ----------------
        viol = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50mhz);
            if (seg_n !== 8'hFF || dig_n !== 4'hF) viol = 1'b1;
            scan_clk = ~scan_clk;
            rco_in   = ~rco_in;
            q_in     = 4'($urandom_range(0, 15));
        end
        check_val("reset_hold_off", {15'h0, viol}, 16'h0);
        check_digit("reset", 4'hF, 8'hFF);

        scan_clk = 1'b0;
        rco_in   = 1'b0;
        q_in     = 4'hA;
        @(negedge clk_50mhz);
        rst = 1'b1;
        viol = 1'b0;
        repeat (20) begin
            @(negedge clk_50mhz);
            if (seg_n !== 8'hFF || dig_n !== 4'hF) viol = 1'b1;
        end
        check_val("post_release_off", {15'h0, viol}, 16'h0);

        // ---------------- first advance: latency and blanking ----------------
        @(negedge clk_50mhz);
        scan_clk = 1'b1;
        lat = 0;
        while (dig_n === 4'hF && lat < 200) begin
            @(negedge clk_50mhz);
            lat++;
            if (lat == 4) scan_clk = 1'b0;
        end
        if (lat >= 4) scan_clk = 1'b0;
        // 3 cycles to the tick, then 50 blanked cycles.
        check_val("tick_plus_blank", 16'(lat), 16'd53);
        repeat (30) @(negedge clk_50mhz);
        check_digit("ptr1_sep", 4'b1101, 8'hFF);
        step(); check_digit("ptr2_ones0", 4'b1011, 8'hC0);
        step(); check_digit("ptr3_lzb",   4'b0111, 8'hFF);
        step(); check_digit("ptr0_qA",    4'b1110, 8'h88);

        // ---------------- rollover count 23 ----------------
        rco_pulses(23);
        step(); check_digit("c23_sep",  4'b1101, 8'hFF);
        step(); check_digit("c23_ones", 4'b1011, 8'hB0);
        step(); check_digit("c23_tens", 4'b0111, 8'hA4);
        step(); check_digit("c23_q",    4'b1110, 8'h88);

        // ---------------- rollover count wraps at 100 ----------------
        rco_pulses(77);
        step();
        step(); check_digit("c100_ones", 4'b1011, 8'hC0);
        step(); check_digit("c100_tens", 4'b0111, 8'hFF);
        step();

        // ---------------- decimal point follows synced rco ----------------
        q_in   = 4'hF;
        rco_in = 1'b1;          // one more rollover: count = 01
        repeat (10) @(negedge clk_50mhz);
        step();
        step(); check_digit("c1_ones", 4'b1011, 8'hF9);
        step();
        step(); check_digit("dp_on_F", 4'b1110, 8'h0E);
        rco_in = 1'b0;
        repeat (10) @(negedge clk_50mhz);
        repeat (4) step();
        check_digit("dp_off_F", 4'b1110, 8'h8E);

        // ---------------- simultaneous rco and scan rise ----------------
        @(negedge clk_50mhz);
        scan_clk = 1'b1;
        rco_in   = 1'b1;
        repeat (4) @(negedge clk_50mhz);
        scan_clk = 1'b0;
        rco_in   = 1'b0;
        repeat (70) @(negedge clk_50mhz);
        check_digit("simul_ptr1", 4'b1101, 8'hFF);
        step(); check_digit("simul_ones2", 4'b1011, 8'hA4);
        step();
        step(); check_digit("simul_ptr0", 4'b1110, 8'h8E);

        // ---------------- q skew glitch 7 -> F -> 8 ----------------
        q_in = 4'h7;
        repeat (10) @(negedge clk_50mhz);
        repeat (3) step();
        for (int d = 0; d < 6; d++) begin
            for (int c = 0; c < 12; c++) begin
                @(negedge clk_50mhz);
                if (c == d)     scan_clk = 1'b1;
                if (c == d + 4) scan_clk = 1'b0;
                if (c == 2)     q_in = 4'hF;
                if (c == 3)     q_in = 4'h8;
            end
            repeat (70) @(negedge clk_50mhz);
            ok = (seg_n == 8'hF8) || (seg_n == 8'h80);
            check_val($sformatf("glitch_d%0d_seg", d), {8'h0, seg_n}, ok ? {8'h0, seg_n} : 16'h0080);
            check_val($sformatf("glitch_d%0d_dig", d), {12'h0, dig_n}, 16'h000E);
            q_in = 4'h7;
            repeat (10) @(negedge clk_50mhz);
            repeat (3) step();
        end

        // ---------------- reset mid-scan ----------------
        step();                         // ptr 0
        step();                         // ptr 1
        step();                         // ptr 2, count = 02
        check_digit("pre_rst_ones", 4'b1011, 8'hA4);
        @(negedge clk_50mhz);
        #3 rst = 1'b0;
        #1 check_digit("async_rst", 4'hF, 8'hFF);
        @(negedge clk_50mhz);
        rst = 1'b1;
        repeat (20) @(negedge clk_50mhz);
        check_digit("post_rst_idle", 4'hF, 8'hFF);
        step();
        step(); check_digit("post_rst_ones", 4'b1011, 8'hC0);
        step(); check_digit("post_rst_tens", 4'b0111, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seg_scan
`default_nettype wire

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Display stage directly downstream of the 1 Hz BCD/hex counter stage.
- Consumes the counter's q_out and rco, plus the 1 kHz divider output, all as asynchronous inputs; operates entirely in the clk_50mhz domain.
- Counts rco rollovers in a two-digit BCD register.
- Time-multiplexes the live count and the rollover count onto a 4-digit common-anode seven-segment display, with inter-digit blanking to suppress ghosting.

Parameters:
BLANK_CYC, 50, clk_50mhz cycles all digits are forced off after each digit change (1 us); legal range 1..1000.
LZB, 1, 1 = blank tens digit (digit 3) when rollover tens value is 0.

Ports:
clk_50mhz  input  1  system clock, 50 MHz.
rst  input  1  asynchronous active-low reset.
scan_clk  input  1  1 kHz scan clock from divider, asynchronous, used as data only.
q_in  input  4  counter value, asynchronous, changes at most once per second.
rco_in  input  1  counter ripple-carry, asynchronous.
seg_n  output  8  segments, active low; [7]=dp, [6:0]=g,f,e,d,c,b,a.
dig_n  output  4  digit enables, active low; [0]=rightmost.

Behaviour:
- Reset (rst=0, asynchronous): seg_n=8'hFF, dig_n=4'hF, digit pointer=0, rollover BCD=00, blank counter=0, all synchronizer flops=0, held q=0. Outputs stay at reset values until the first scan_tick after release.
- Synchronizers: scan_clk and rco_in each pass through two flops, followed by a rising-edge detector.
  - scan_tick is a 1-cycle pulse 3 clk_50mhz cycles after a scan_clk rise.
  - rco_rise is the equivalent pulse for rco_in.
- q_in capture:
  - q_in passes through a 2-flop sync.
  - The held value updates only when two consecutive synced samples are equal.
  - This rejects multi-bit skew, with at most 4 cycles latency.
- Rollover counter, ones/tens BCD:
  - Increments by 1 on rco_rise.
  - Ones wraps 9→0 and carries into tens.
  - 99→00 wraps silently.
- Digit pointer, 2-bit:
  - Advances on scan_tick: 0→1→2→3→0.
  - The same scan_tick reloads the blank counter to BLANK_CYC.
- Blanking:
  - While the blank counter ≠ 0, dig_n=4'hF and the counter decrements each cycle.
  - When it reaches 0, dig_n asserts the single bit dig_n[ptr]=0.
  - A scan_tick arriving during blanking restarts blanking and advances the pointer.
- Digit content:
  - ptr 0: hex7seg(held q); dp lit (seg_n[7]=0) while the synced rco is high.
  - ptr 1: all segments off (8'hFF), separator.
  - ptr 2: hex7seg(ones).
  - ptr 3: hex7seg(tens), or 8'hFF if LZB=1 and tens=0.
  - dp is off for ptr 1..3.
- seg_n is registered; it is updated in the same cycle as the pointer so it is stable before dig_n asserts.
- Simultaneous rco_rise and scan_tick: both take effect in the same cycle. The new rollover value is shown on its digit's next visit.
- Reset mid-scan: all outputs return to off immediately and asynchronously; no partial digit is shown.
- Hex encodings (active low, [6:0]):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Decomposition:
- Shared package seg_pkg holds:
  - the 16-entry hex→segment constant table;
  - SEG_OFF=8'hFF and DIG_OFF=4'hF;
  - digit index constants DIG_Q=0, DIG_SEP=1, DIG_ONES=2, DIG_TENS=3.
- One combinational sub-module, hex7seg (4-bit in, 7-bit active-low out), reads the table.
- Synchronizers, the edge detector, and the scan FSM live in seg_scan.

Test Plan:
- Reset: hold rst=0 with toggling inputs → seg_n=FF, dig_n=F throughout; after release and before any scan_clk rise → outputs unchanged.
- Scan order and blanking, BLANK_CYC=50:
  - q_in=4'hA held, scan_clk rise → scan_tick 3 cycles later.
  - dig_n=F for 50 cycles, then dig_n=4'b1101 (ptr 1) with seg_n=FF.
  - Next rise → ptr 2, seg_n=8'hC0 (ones=0); then ptr 3, seg_n=FF (LZB).
  - Then ptr 0, seg_n=8'h88.
- Rollover count: 23 rco_in pulses → ptr 2 shows seg_n=8'hB0 ('3'), ptr 3 shows 8'hA4 ('2'); after 100 total pulses, ptr 2 shows C0 and ptr 3 shows FF.
- Decimal point: rco_in held high while ptr=0 → seg_n=8'h0E for q=F (dp and F); rco_in low → 8'h8E.
- Simultaneous/skew: rco_in rise in the same cycle as scan_clk rise → count increments exactly once and the pointer advances exactly once. q_in stepping 7→8 with a 1-cycle 4'hF glitch → held value never equals F.
- Mid-operation reset: assert rst during active digit 2 → dig_n=F asynchronously, same cycle; count=00 after release.
